// File: rtl/div_iter.sv
`default_nettype none
// ============================================================================
// Module   : div_iter
// Brief    : Iterative radix-2 restoring divider (DIV/DIVU), one quotient bit
//            per cycle, start/ready handshake, returns {remainder, quotient}.
// Revision : 1.0 - initial release
// ============================================================================
module div_iter (
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o
);

  typedef enum logic [1:0] {
    S_FREE    = 2'd0,
    S_BY_ZERO = 2'd1,
    S_ON      = 2'd2,
    S_END     = 2'd3
  } state_t;

  localparam logic [5:0] c_LAST_ITER = 6'd31;

  state_t      r_state, w_state_nxt;
  logic [64:0] r_work, w_work_nxt;
  logic [5:0]  r_cnt, w_cnt_nxt;
  logic [31:0] r_divisor, w_divisor_nxt;
  logic        r_neg_q, w_neg_q_nxt;
  logic        r_neg_r, w_neg_r_nxt;
  logic [63:0] r_result, w_result_nxt;
  logic        r_ready, w_ready_nxt;

  logic [31:0] w_dvd_mag;
  logic [31:0] w_dvs_mag;
  logic [64:0] w_shift;
  logic [33:0] w_diff;
  logic [64:0] w_iter;
  logic [31:0] w_q_fix;
  logic [31:0] w_r_fix;

  // Magnitudes of the incoming operands; 0x80000000 maps to 2^31 unsigned.
  assign w_dvd_mag = (signed_div_i && opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
  assign w_dvs_mag = (signed_div_i && opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;

  // One restoring step; the extra MSB of the difference is its sign.
  assign w_shift = r_work << 1;
  assign w_diff  = {1'b0, w_shift[64:32]} - {2'b00, r_divisor};
  assign w_iter  = w_diff[33] ? w_shift : {w_diff[32:0], w_shift[31:1], 1'b1};

  assign w_q_fix = r_neg_q ? (~w_iter[31:0] + 32'd1)  : w_iter[31:0];
  assign w_r_fix = r_neg_r ? (~w_iter[63:32] + 32'd1) : w_iter[63:32];

  always_comb begin
    w_state_nxt   = r_state;
    w_work_nxt    = r_work;
    w_cnt_nxt     = r_cnt;
    w_divisor_nxt = r_divisor;
    w_neg_q_nxt   = r_neg_q;
    w_neg_r_nxt   = r_neg_r;
    w_result_nxt  = r_result;
    w_ready_nxt   = r_ready;
    case (r_state)
      S_FREE: begin
        if (start_i && !annul_i) begin
          if (opdata2_i != 32'd0) begin
            w_state_nxt   = S_ON;
            w_work_nxt    = {33'd0, w_dvd_mag};
            w_cnt_nxt     = 6'd0;
            w_divisor_nxt = w_dvs_mag;
            w_neg_q_nxt   = signed_div_i && (opdata1_i[31] ^ opdata2_i[31]);
            w_neg_r_nxt   = signed_div_i && opdata1_i[31];
          end else begin
            w_state_nxt = S_BY_ZERO;
          end
        end
      end
      S_BY_ZERO: begin
        w_state_nxt  = S_END;
        w_result_nxt = 64'd0;
        w_ready_nxt  = 1'b1;
      end
      S_ON: begin
        if (annul_i) begin
          w_state_nxt  = S_FREE;
          w_result_nxt = 64'd0;
          w_ready_nxt  = 1'b0;
        end else begin
          w_work_nxt = w_iter;
          w_cnt_nxt  = r_cnt + 6'd1;
          if (r_cnt == c_LAST_ITER) begin
            w_state_nxt  = S_END;
            w_result_nxt = {w_r_fix, w_q_fix};
            w_ready_nxt  = 1'b1;
          end
        end
      end
      S_END: begin
        if (!start_i) begin
          w_state_nxt  = S_FREE;
          w_result_nxt = 64'd0;
          w_ready_nxt  = 1'b0;
        end
      end
      default: begin
        w_state_nxt  = S_FREE;
        w_result_nxt = 64'd0;
        w_ready_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_FREE;
      r_work    <= 65'd0;
      r_cnt     <= 6'd0;
      r_divisor <= 32'd0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_result  <= 64'd0;
      r_ready   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_work    <= w_work_nxt;
      r_cnt     <= w_cnt_nxt;
      r_divisor <= w_divisor_nxt;
      r_neg_q   <= w_neg_q_nxt;
      r_neg_r   <= w_neg_r_nxt;
      r_result  <= w_result_nxt;
      r_ready   <= w_ready_nxt;
    end
  end

  assign result_o = r_result;
  assign ready_o  = r_ready;

endmodule
`default_nettype wire

// File: tb/tb_div_iter.sv
`default_nettype none
// ============================================================================
// Module   : tb_div_iter
// Brief    : Scoreboard bench for div_iter: latency, results, handshake, abort.
// Revision : 1.0 - initial release
// ============================================================================
module tb_div_iter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        signed_div_i = 1'b0;
  logic [31:0] opdata1_i = 32'd0;
  logic [31:0] opdata2_i = 32'd0;
  logic        start_i = 1'b0;
  logic        annul_i = 1'b0;
  logic [63:0] result_o;
  logic        ready_o;

  int n_cmp = 0;
  int n_bad = 0;
  logic [63:0] sb[$];

  div_iter dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] model(input bit s, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb_, sq, sr;
    if (b == 32'd0) return 64'd0;
    if (!s) return {a % b, a / b};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
    sa = a; sb_ = b;
    sq = sa / sb_;
    sr = sa % sb_;
    return {sr, sq};
  endfunction

  // Drives one request and records what the DUT did; no judging here.
  task automatic do_op(input bit s, input logic [31:0] a, input logic [31:0] b,
                       input int hold, input bit scramble,
                       output int edges, output logic [63:0] res, output bit hold_ok,
                       output bit early_out, output logic post_rdy, output logic [63:0] post_res);
    @(negedge clk);
    signed_div_i = s; opdata1_i = a; opdata2_i = b; start_i = 1'b1;
    edges = 0; early_out = 1'b0;
    while (edges < 100) begin
      @(posedge clk); #1;
      edges++;
      if (scramble && edges == 5) begin
        opdata1_i = $urandom; opdata2_i = $urandom; signed_div_i = ~s;
      end
      if (ready_o) break;
      if (result_o !== 64'd0) early_out = 1'b1;
    end
    res = result_o;
    hold_ok = 1'b1;
    repeat (hold) begin
      @(posedge clk); #1;
      if (ready_o !== 1'b1 || result_o !== res) hold_ok = 1'b0;
    end
    start_i = 1'b0;
    @(posedge clk); #1;
    post_rdy = ready_o;
    post_res = result_o;
  endtask

  task automatic watch_idle(input int n, output bit saw);
    saw = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
      if (ready_o) saw = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    if (ready_o !== 1'b0) begin n_bad++; $display("FAIL reset_ready got=%b want=0", ready_o); end
    n_cmp++;
    if (result_o !== 64'd0) begin n_bad++; $display("FAIL reset_result got=%h want=0", result_o); end
    n_cmp++;
    rst = 1'b0;
  endtask

  task automatic test_arith(input string name, input bit s, input logic [31:0] a, input logic [31:0] b,
                            input logic [63:0] golden, input int hold);
    int edges; logic [63:0] res, exp, post_res; bit hold_ok, early; logic post_rdy;
    int lat;
    lat = (b == 32'd0) ? 2 : 33;
    sb.push_back(model(s, a, b));
    do_op(s, a, b, hold, 1'b0, edges, res, hold_ok, early, post_rdy, post_res);
    exp = sb.pop_front();
    if (exp !== golden) begin n_bad++; $display("FAIL %s_model got=%h want=%h", name, exp, golden); end
    n_cmp++;
    if (edges !== lat) begin n_bad++; $display("FAIL %s_latency got=%0d want=%0d", name, edges, lat); end
    n_cmp++;
    if (res !== exp) begin n_bad++; $display("FAIL %s_result got=%h want=%h", name, res, exp); end
    n_cmp++;
    if (early !== 1'b0) begin n_bad++; $display("FAIL %s_result_before_ready got=1 want=0", name); end
    n_cmp++;
    if (hold > 0) begin
      if (hold_ok !== 1'b1) begin n_bad++; $display("FAIL %s_hold got=0 want=1", name); end
      n_cmp++;
    end
    if (post_rdy !== 1'b0 || post_res !== 64'd0) begin
      n_bad++; $display("FAIL %s_clear got=%b/%h want=0/0", name, post_rdy, post_res);
    end
    n_cmp++;
  endtask

  task automatic test_unsigned();
    test_arith("u100_7", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 0);
    test_arith("u_fff9_2", 1'b0, 32'hFFFF_FFF9, 32'd2, 64'h00000001_7FFFFFFC, 0);
  endtask

  task automatic test_signed();
    test_arith("s_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 0);
    test_arith("s_5_m3", 1'b1, 32'd5, 32'hFFFF_FFFD, 64'h00000002_FFFFFFFF, 0);
    test_arith("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 64'h00000000_80000000, 0);
  endtask

  task automatic test_div_zero();
    test_arith("u_dz", 1'b0, 32'd5, 32'd0, 64'd0, 3);
    test_arith("s_dz", 1'b1, 32'h8000_0000, 32'd0, 64'd0, 3);
  endtask

  task automatic test_annul();
    bit saw;
    @(negedge clk);
    signed_div_i = 1'b0; opdata1_i = 32'd1234; opdata2_i = 32'd5; start_i = 1'b1;
    repeat (11) @(posedge clk);
    #1 annul_i = 1'b1;
    @(posedge clk); #1;
    if (ready_o !== 1'b0 || result_o !== 64'd0) begin
      n_bad++; $display("FAIL annul_outputs got=%b/%h want=0/0", ready_o, result_o);
    end
    n_cmp++;
    watch_idle(5, saw);
    start_i = 1'b0; annul_i = 1'b0;
    begin
      bit saw2;
      watch_idle(40, saw2);
      saw = saw | saw2;
    end
    if (saw !== 1'b0) begin n_bad++; $display("FAIL annul_no_ready got=1 want=0"); end
    n_cmp++;
    test_arith("after_annul_9_3", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 0);
  endtask

  task automatic test_rst_mid();
    bit saw;
    @(negedge clk);
    signed_div_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd3; start_i = 1'b1;
    repeat (21) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    if (ready_o !== 1'b0 || result_o !== 64'd0) begin
      n_bad++; $display("FAIL rst_mid_outputs got=%b/%h want=0/0", ready_o, result_o);
    end
    n_cmp++;
    rst = 1'b0; start_i = 1'b0;
    watch_idle(40, saw);
    if (saw !== 1'b0) begin n_bad++; $display("FAIL rst_mid_no_ready got=1 want=0"); end
    n_cmp++;
    test_arith("after_rst_77_7", 1'b0, 32'd77, 32'd7, 64'h00000000_0000000B, 0);
  endtask

  task automatic test_operand_change();
    int edges; logic [63:0] res, exp, post_res; bit hold_ok, early; logic post_rdy;
    sb.push_back(model(1'b1, 32'hFFFF_FF00, 32'd13));
    do_op(1'b1, 32'hFFFF_FF00, 32'd13, 0, 1'b1, edges, res, hold_ok, early, post_rdy, post_res);
    exp = sb.pop_front();
    if (edges !== 33) begin n_bad++; $display("FAIL scramble_latency got=%0d want=33", edges); end
    n_cmp++;
    if (res !== exp) begin n_bad++; $display("FAIL scramble_result got=%h want=%h", res, exp); end
    n_cmp++;
  endtask

  task automatic test_back_to_back();
    int edges; logic [63:0] res, exp, post_res; bit hold_ok, early; logic post_rdy;
    bit s; logic [31:0] a, b;
    for (int i = 0; i < 10; i++) begin
      s = $urandom_range(0, 1);
      a = $urandom;
      b = (i == 3) ? 32'd0 : ((i % 2 == 0) ? $urandom : $urandom_range(1, 300));
      if (i == 6) b = 32'hFFFF_FFFF;
      sb.push_back(model(s, a, b));
      do_op(s, a, b, 0, 1'b0, edges, res, hold_ok, early, post_rdy, post_res);
      exp = sb.pop_front();
      if (edges !== ((b == 32'd0) ? 2 : 33)) begin
        n_bad++; $display("FAIL b2b_latency[%0d] got=%0d a=%h b=%h s=%0d", i, edges, a, b, s);
      end
      n_cmp++;
      if (res !== exp) begin
        n_bad++; $display("FAIL b2b_result[%0d] got=%h want=%h a=%h b=%h s=%0d", i, res, exp, a, b, s);
      end
      n_cmp++;
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_annul();
    test_rst_mid();
    test_operand_change();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/div_iter.md
# div_iter

Iterative radix-2 restoring divider. It is the responder side of the EX-stage start/ready divide handshake used by DIV and DIVU. It accepts a 32-bit dividend and divisor, runs one quotient bit per cycle, and returns `{remainder, quotient}` so EX can write HI and LO. EX holds `start_i` and raises `stallreq_for_ex` until `ready_o` pulses.

## Interface
- No parameters; the datapath is fixed at 32 bits.
- `clk` input 1: clock; all state updates on the rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `signed_div_i` input 1: 1 = signed (DIV), 0 = unsigned (DIVU); sampled with `start_i`.
- `opdata1_i` input 32: dividend; sampled with `start_i`.
- `opdata2_i` input 32: divisor; sampled with `start_i`.
- `start_i` input 1: request; held high by EX until it sees `ready_o`.
- `annul_i` input 1: abort the operation in progress.
- `result_o` output 64: `{remainder[63:32], quotient[31:0]}`; valid only while `ready_o`=1, otherwise 0.
- `ready_o` output 1: result valid (DivResultReady).

## Operation
- States:
  - FREE: idle, accepting requests.
  - BY_ZERO: divisor was zero.
  - ON: iterating.
  - END: result presented.
- FREE:
  - `start_i`=1, `annul_i`=0, `opdata2_i`≠0 → ON.
    - Latch `opdata1_i`, `opdata2_i` and `signed_div_i`.
    - Convert to magnitudes: in signed mode, two's-complement negate any operand with bit31=1.
    - Load the 65-bit working register as `{33'b0, |dividend|}`; clear the 6-bit counter.
  - `start_i`=1, `annul_i`=0, `opdata2_i`=0 → BY_ZERO.
  - Otherwise stay in FREE.
- BY_ZERO: unconditionally → END with `result_o`=64'h0 and `ready_o`=1.
- ON, `annul_i`=1: → FREE; `result_o`=0, `ready_o`=0; the partial result is discarded.
- ON, `annul_i`=0: one iteration per cycle.
  - Shift the working register left by 1.
  - Compute `diff = work[64:32] - {1'b0, |divisor|}`.
  - If `diff` is non-negative: `work[64:32]` = `diff` and `work[0]` = 1. Otherwise keep the shifted value.
  - Counter increments.
- ON, after iteration 31 (counter reaches 32):
  - Apply sign correction.
    - Quotient is negated if signed and the operand signs differ.
    - Remainder is negated if signed and the dividend is negative.
  - Load `result_o`, set `ready_o`=1, → END.
- ON ignores `start_i` and input operand changes; only `annul_i` or `rst` ends it early.
- END:
  - While `start_i`=1: hold `result_o` and `ready_o`.
  - When `start_i`=0: → FREE and clear `result_o` and `ready_o`.
- Arithmetic:
  - Unsigned: `Q=floor(a/b)`, `R=a-Q*b`.
  - Signed: truncate toward zero; the remainder takes the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF signed gives `Q`=0x80000000, `R`=0. Wrap, no exception.
- Divide by zero always returns 0 for both HI and LO. It is architecturally undefined, but defined here as 0.

## Timing
- Reset: state = FREE; `result_o`=0, `ready_o`=0; counter and working register = 0.
- `rst` mid-operation (any state) returns to FREE on that edge; no `ready_o` follows.
- Latency, counting E0 as the edge that samples `start_i`=1 in FREE:
  - Normal: `ready_o` rises after E32, i.e. 33 edges.
  - Divide by zero: `ready_o` rises after E1.
- `ready_o` and `result_o` are registered with no combinational input-to-output path. EX may drop `start_i` combinationally from `ready_o`.
- Handshake:
  - EX deasserts `start_i` in the same cycle `ready_o`=1.
  - The next edge returns the block to FREE, so `ready_o` is high for exactly one cycle.
  - If `start_i` stays high, `ready_o` holds indefinitely.
- Back-to-back: a new request is accepted no earlier than the edge after the return to FREE. There is at least one idle FREE cycle between operations.
- `annul_i` and `start_i` both high in FREE: the request is not accepted.
- `annul_i` in END or BY_ZERO has no effect.

## Test plan
- Unsigned 100 / 7:
  - `ready_o` rises exactly 33 edges after start is sampled.
  - `result_o`=64'h00000002_0000000E.
  - Dropping `start_i` clears both outputs on the next edge.
- Signed -7 / 2 (0xFFFFFFF9 / 2) → `result_o`=64'hFFFFFFFF_FFFFFFFD. Unsigned 0xFFFFFFF9 / 2 → 64'h00000001_7FFFFFFC.
- Divisor 0 (either mode) → `ready_o` after 2 edges, `result_o`=0. Holding `start_i` high for 3 more cycles keeps `ready_o`=1.
- Signed 0x80000000 / 0xFFFFFFFF → 64'h00000000_80000000. Signed 5 / -3 → 64'h00000002_FFFFFFFF.
- Abort cases:
  - `annul_i` pulsed at iteration 10 → FREE next edge, `ready_o` never rises.
  - A following unsigned 9 / 3 → 64'h0_00000003 with full 33-edge latency.
- Assert `rst` at iteration 20 → outputs 0, state FREE. Changing operands mid-ON does not alter the result of a normal run.
